// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - register map constants and byte-lane helper for input_conditioner
package input_cond_pkg;

    localparam logic [1:0] REG_LEVEL  = 2'd0;
    localparam logic [1:0] REG_EDGE   = 2'd1;
    localparam logic [1:0] REG_IRQ_EN = 2'd2;

    localparam int RELEASE_LSB = 8;
    localparam int SWITCH_LSB  = 16;

    // Core bus carries words in the opposite byte order to the register contents.
    function automatic logic [31:0] byteswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - core data-bus slice seen by the input_conditioner register window
interface input_conditioner_if;
    logic        bus_lock;
    logic        memory_mode;
    logic [29:0] data_address;
    logic [3:0]  data_mask;
    logic [31:0] data_out;
    logic        sel;
    logic [31:0] rd_data;

    modport master (
        output bus_lock, memory_mode, data_address, data_mask, data_out,
        input  sel, rd_data
    );

    modport slave (
        input  bus_lock, memory_mode, data_address, data_mask, data_out,
        output sel, rd_data
    );
endinterface

// File: rtl/input_conditioner_debounce_cell.sv
// rtl/input_conditioner_debounce_cell.sv - one-bit 2-flop synchroniser plus hold-time debouncer
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit INVERT          = 1'b0
) (
    input  logic clk,
    input  logic sync_rst,
    input  logic pin,
    output logic stable
);
    localparam int              CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level;
    logic [CW-1:0] cnt;

    assign level = sync_q[1] ^ INVERT;

    // Counter restarts whenever the synchronised level matches the accepted one,
    // so only an unbroken run of DEBOUNCE_CYCLES differing samples is accepted.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            sync_q <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin};
            if (level == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= level;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounced buttons/switches register window with sticky edges and irq (INPUT_COND_RELEASE_EN adds release events)
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int          N_BUTTONS         = 4,
    parameter int          N_SWITCHES        = 9,
    parameter int          DEBOUNCE_CYCLES   = 50000,
    parameter int          BUTTON_ACTIVE_LOW = 1,
    parameter logic [29:0] BASE_WORD_ADDR    = 30'h1001
) (
    input  logic                  clk,
    input  logic                  sync_rst,
    input  logic                  clk_en,
    input  logic [N_BUTTONS-1:0]  push_buttons,
    input  logic [N_SWITCHES-1:0] switches,
    input_conditioner_if.slave    bus,
    output logic                  irq
);
    localparam logic [31:0] PRESS_BITS = 32'((64'd1 << N_BUTTONS) - 64'd1);
`ifdef INPUT_COND_RELEASE_EN
    localparam logic [31:0] VALID_BITS = PRESS_BITS | (PRESS_BITS << RELEASE_LSB);
`else
    localparam logic [31:0] VALID_BITS = PRESS_BITS;
`endif

    logic [N_BUTTONS-1:0]  btn_stable;
    logic [N_BUTTONS-1:0]  btn_prev;
    logic [N_SWITCHES-1:0] sw_stable;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INVERT         (BUTTON_ACTIVE_LOW != 0)
        ) u_cell (
            .clk     (clk),
            .sync_rst(sync_rst),
            .pin     (push_buttons[i]),
            .stable  (btn_stable[i])
        );
    end

    for (genvar i = 0; i < N_SWITCHES; i++) begin : g_sw
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INVERT         (1'b0)
        ) u_cell (
            .clk     (clk),
            .sync_rst(sync_rst),
            .pin     (switches[i]),
            .stable  (sw_stable[i])
        );
    end

    logic [29:0] addr_off;
    logic [1:0]  reg_idx;
    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] wr_data;
    logic [31:0] wr_mask;
    logic [31:0] edge_q;
    logic [31:0] en_q;
    logic [31:0] edge_set;
    logic [31:0] edge_clr;
    logic [31:0] reg_rdata;
    logic [31:0] rd_q;

    // Wrapping subtraction gives a single compare for the 4-word window.
    assign addr_off = bus.data_address - BASE_WORD_ADDR;
    assign reg_idx  = addr_off[1:0];
    assign bus.sel  = (addr_off[29:2] == '0);
    assign bus_rd   = clk_en & bus.bus_lock & ~bus.memory_mode & bus.sel;
    assign bus_wr   = clk_en & bus.bus_lock &  bus.memory_mode & bus.sel;

    assign wr_data = byteswap32(bus.data_out);
    assign wr_mask = byteswap32({{8{bus.data_mask[3]}}, {8{bus.data_mask[2]}},
                                 {8{bus.data_mask[1]}}, {8{bus.data_mask[0]}}});

`ifdef INPUT_COND_RELEASE_EN
    assign edge_set = 32'(btn_stable & ~btn_prev) | (32'(~btn_stable & btn_prev) << RELEASE_LSB);
`else
    assign edge_set = 32'(btn_stable & ~btn_prev);
`endif
    assign edge_clr = (bus_wr && reg_idx == REG_EDGE) ? (wr_data & wr_mask) : '0;

    always_comb begin
        reg_rdata = '0;
        case (reg_idx)
            REG_LEVEL:  reg_rdata = 32'(btn_stable) | (32'(sw_stable) << SWITCH_LSB);
            REG_EDGE:   reg_rdata = edge_q;
            REG_IRQ_EN: reg_rdata = en_q;
            default:    reg_rdata = '0;
        endcase
    end

    // Edge capture and irq run every clk; only bus accesses honour clk_en.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            btn_prev <= '0;
            edge_q   <= '0;
            en_q     <= '0;
            rd_q     <= '0;
            irq      <= 1'b0;
        end else begin
            btn_prev <= btn_stable;
            edge_q   <= ((edge_q & ~edge_clr) | edge_set) & VALID_BITS;
            irq      <= |(edge_q & en_q);
            if (bus_wr && reg_idx == REG_IRQ_EN) begin
                en_q <= ((en_q & ~wr_mask) | (wr_data & wr_mask)) & VALID_BITS;
            end
            if (bus_rd) begin
                rd_q <= byteswap32(reg_rdata);
            end
        end
    end

    assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed and random checks of input_conditioner against a window-rule model
module tb_input_conditioner;
    localparam int          NB   = 4;
    localparam int          NS   = 9;
    localparam int          NI   = NB + NS;
    localparam int          D    = 4;
    localparam logic [29:0] BASE = 30'h1001;
`ifdef INPUT_COND_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          sync_rst;
    logic          clk_en;
    logic [NB-1:0] push_buttons;
    logic [NS-1:0] switches;
    logic          irq;

    input_conditioner_if bus();

    input_conditioner #(
        .N_BUTTONS        (NB),
        .N_SWITCHES       (NS),
        .DEBOUNCE_CYCLES  (D),
        .BUTTON_ACTIVE_LOW(1),
        .BASE_WORD_ADDR   (BASE)
    ) dut (
        .clk         (clk),
        .sync_rst    (sync_rst),
        .clk_en      (clk_en),
        .push_buttons(push_buttons),
        .switches    (switches),
        .bus         (bus),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int          e;
    bit          pin_h [NI][16];
    bit          s_h   [NI][16];
    bit          m_stable [NI];
    bit          m_prev   [NB];
    logic [31:0] m_edge, m_en, m_rd;
    bit          m_irq;

    function automatic logic [31:0] bsw(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [31:0] ev(input logic [31:0] press, input logic [31:0] rel);
        return bsw(press | (REL ? (rel << 8) : 32'h0));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A level is accepted once D consecutive synchronised samples all differ from it.
    task automatic model_edge();
        logic [31:0] lvl, val, wd, wm, clr, set, valid;
        logic [29:0] d;
        logic [1:0]  off;
        bit          sel_m, flip;
        bit [NI-1:0] nst;
        if (sync_rst) begin
            for (int i = 0; i < NI; i++) m_stable[i] = 1'b0;
            for (int b = 0; b < NB; b++) m_prev[b] = 1'b0;
            m_edge = '0; m_en = '0; m_rd = '0; m_irq = 1'b0; e = 0;
            return;
        end
        e++;
        for (int i = 0; i < NI; i++) begin
            bit raw, s;
            if (i < NB) raw = push_buttons[i];
            else        raw = switches[i-NB];
            pin_h[i][e%16] = raw;
            s = (e >= 3) ? pin_h[i][(e-2)%16] : 1'b0;
            if (i < NB) s = ~s;
            s_h[i][e%16] = s;
            flip = (e >= D);
            for (int j = 0; j < D; j++)
                if (flip && s_h[i][(e-j)%16] == m_stable[i]) flip = 1'b0;
            nst[i] = flip ? ~m_stable[i] : m_stable[i];
        end
        lvl = '0;
        for (int i = 0; i < NI; i++) begin
            if (i < NB) lvl[i] = m_stable[i];
            else        lvl[16 + i - NB] = m_stable[i];
        end
        valid = REL ? 32'h0000_0F0F : 32'h0000_000F;
        set = '0;
        for (int b = 0; b < NB; b++) begin
            if (m_stable[b] && !m_prev[b]) set[b] = 1'b1;
            if (REL && !m_stable[b] && m_prev[b]) set[8+b] = 1'b1;
        end
        d     = bus.data_address - BASE;
        sel_m = (d < 30'd4);
        off   = d[1:0];
        case (off)
            2'd0:    val = lvl;
            2'd1:    val = m_edge;
            2'd2:    val = m_en;
            default: val = '0;
        endcase
        wd = bsw(bus.data_out);
        for (int k = 0; k < 4; k++) wm[8*k +: 8] = {8{bus.data_mask[3-k]}};
        clr = '0;
        m_irq = |(m_edge & m_en);
        if (clk_en && bus.bus_lock && sel_m) begin
            if (!bus.memory_mode) m_rd = bsw(val);
            else if (off == 2'd1) clr = wd & wm;
            else if (off == 2'd2) m_en = ((m_en & ~wm) | (wd & wm)) & valid;
        end
        m_edge = ((m_edge & ~clr) | set) & valid;
        for (int b = 0; b < NB; b++) m_prev[b] = m_stable[b];
        for (int i = 0; i < NI; i++) m_stable[i] = nst[i];
    endtask

    task automatic step();
        logic [29:0] d;
        #1;
        d = bus.data_address - BASE;
        check("sel", {31'b0, bus.sel}, {31'b0, (d < 30'd4)});
        model_edge();
        @(posedge clk);
        #1;
        check("rd_data", bus.rd_data, m_rd);
        check("irq", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic bus_idle();
        bus.bus_lock = 1'b0; bus.memory_mode = 1'b0; bus.data_address = '0;
        bus.data_mask = '0; bus.data_out = '0;
    endtask

    task automatic bus_read(input int off);
        bus.bus_lock = 1'b1; bus.memory_mode = 1'b0; bus.data_address = BASE + 30'(off);
        bus.data_mask = '0; bus.data_out = '0;
    endtask

    task automatic bus_write(input int off, input logic [31:0] data, input logic [3:0] mask);
        bus.bus_lock = 1'b1; bus.memory_mode = 1'b1; bus.data_address = BASE + 30'(off);
        bus.data_mask = mask; bus.data_out = data;
    endtask

    initial begin
        sync_rst = 1'b1; clk_en = 1'b1; push_buttons = '1; switches = '0;
        bus_idle();
        repeat (3) step();
        check("reset_rd", bus.rd_data, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        sync_rst = 1'b0;
        repeat (8) step();

        // button0 held: LEVEL shows it 6 clk after the pin change
        bus_read(0);
        push_buttons[0] = 1'b0;
        repeat (6) step();
        check("level_b0_early", bus.rd_data, 32'h0);
        step();
        check("level_b0", bus.rd_data, 32'h0100_0000);
        repeat (3) step();
        bus_read(1);
        step();
        check("edge_b0", bus.rd_data, 32'h0100_0000);
        push_buttons[0] = 1'b1; bus_idle();
        repeat (8) step();

        // 3-clk glitch on button1 is rejected
        bus_write(1, 32'hFFFF_FFFF, 4'hF);
        step();
        bus_idle();
        push_buttons[1] = 1'b0;
        repeat (3) step();
        push_buttons[1] = 1'b1;
        repeat (8) step();
        check("glitch_irq", {31'b0, irq}, 32'h0);
        bus_read(1); step();
        check("glitch_edge", bus.rd_data, 32'h0);
        bus_read(0); step();
        check("glitch_level", bus.rd_data, 32'h0);

        // buttons 0 and 2, then byte-masked W1C
        bus_idle();
        push_buttons[0] = 1'b0; push_buttons[2] = 1'b0;
        repeat (7) step();
        push_buttons[0] = 1'b1; push_buttons[2] = 1'b1;
        repeat (8) step();
        bus_read(1); step();
        check("edge_b02", bus.rd_data, ev(32'h5, 32'h5));
        bus_write(1, 32'h0100_0000, 4'b1000); step();
        bus_read(1); step();
        check("edge_w1c_b0", bus.rd_data, ev(32'h4, 32'h5));
        bus_write(1, 32'hFFFF_FFFF, 4'b0000); step();
        bus_read(1); step();
        check("edge_mask0", bus.rd_data, ev(32'h4, 32'h5));

        // irq enable, then set-wins against a same-cycle W1C
        bus_write(2, 32'h0400_0000, 4'hF); step();
        bus_idle(); step();
        check("irq_on", {31'b0, irq}, 32'h1);
        push_buttons[2] = 1'b0;
        repeat (6) step();
        bus_write(1, 32'h0400_0000, 4'b1000); step();
        bus_idle(); step();
        check("irq_set_wins", {31'b0, irq}, 32'h1);
        bus_read(1); step();
        check("edge_set_wins", bus.rd_data, ev(32'h4, 32'h5));
        push_buttons[2] = 1'b1; bus_idle();
        repeat (8) step();

        // clk_en low: edges still captured, bus ignored
        bus_write(1, 32'hFFFF_FFFF, 4'hF); step();
        bus_write(2, 32'h0F00_0000, 4'hF); step();
        bus_read(2); step();
        check("en_0f", bus.rd_data, 32'h0F00_0000);
        clk_en = 1'b0;
        bus_write(2, 32'h0, 4'hF);
        push_buttons[3] = 1'b0;
        repeat (7) step();
        bus_read(1); step();
        push_buttons[3] = 1'b1;
        repeat (7) step();
        check("rd_held", bus.rd_data, 32'h0F00_0000);
        check("irq_b3", {31'b0, irq}, 32'h1);
        clk_en = 1'b1;
        bus_read(1); step();
        check("edge_b3", bus.rd_data, ev(32'h8, 32'h8));
        bus_read(2); step();
        check("en_kept", bus.rd_data, 32'h0F00_0000);

        // reset in the middle of a switch4 debounce
        bus_idle();
        switches[4] = 1'b1;
        repeat (4) step();
        sync_rst = 1'b1; step();
        sync_rst = 1'b0;
        check("rst2_rd", bus.rd_data, 32'h0);
        check("rst2_irq", {31'b0, irq}, 32'h0);
        bus_read(0);
        repeat (6) step();
        check("sw4_early", bus.rd_data, 32'h0);
        step();
        check("sw4_level", bus.rd_data, 32'h0000_1000);

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 7) == 0) push_buttons[i] = ~push_buttons[i];
            for (int i = 0; i < NS; i++)
                if ($urandom_range(0, 7) == 0) switches[i] = ~switches[i];
            sync_rst         = ($urandom_range(0, 99) == 0);
            clk_en           = ($urandom_range(0, 3) != 0);
            bus.bus_lock     = 1'($urandom_range(0, 1));
            bus.memory_mode  = ($urandom_range(0, 2) == 0);
            bus.data_address = BASE - 30'd2 + 30'($urandom_range(0, 7));
            bus.data_mask    = 4'($urandom);
            bus.data_out     = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Memory-mapped input peripheral that sits between the board push buttons/switches and the core data bus.
- Synchronises and debounces every input.
- Captures sticky press events and raises a maskable interrupt.
- Returns register reads with the same one-cycle registered latency and byte-lane order as data RAM.
- Its read mux output feeds the toplevel MemoryMap; it replaces the raw switch and button taps there.

Parameters:
N_BUTTONS, 4, number of push-button inputs (1..8)
N_SWITCHES, 9, number of switch inputs (1..16)
DEBOUNCE_CYCLES, 50000, clk cycles an input must hold a new level before it is accepted (>=2)
BUTTON_ACTIVE_LOW, 1, 1 = raw button pins are active-low and are inverted after sync
BASE_WORD_ADDR, 30'h1001, word address of register 0

Ports:
clk  in  1  system clock
sync_rst  in  1  synchronous reset, active-high
clk_en  in  1  bus-side clock enable
push_buttons  in  N_BUTTONS  raw button pins, asynchronous
switches  in  N_SWITCHES  raw switch pins, asynchronous
bus_lock  in  1  bus access valid
memory_mode  in  1  1 = write, 0 = read
data_address  in  30  word address
data_mask  in  4  byte-lane write enables
data_out  in  32  core write data, core byte order
sel  out  1  combinational: address hits the 4-word register window
rd_data  out  32  registered read data, core byte order
irq  out  1  registered: |(EDGE & IRQ_EN)

Behaviour:
- Reset values: all outputs 0, all registers 0, sync flops 0, debounce counters 0.
- Input path (free-running every clk, not gated by clk_en):
  - 2-flop synchroniser per input.
  - Buttons are inverted after sync when BUTTON_ACTIVE_LOW.
  - Per input: if sync == stable, counter <= 0. Otherwise counter++. When counter == DEBOUNCE_CYCLES-1, stable <= sync and counter <= 0.
  - Counter width is $clog2(DEBOUNCE_CYCLES); it never wraps.
  - Latency from a clean pin change to the stable change is 2 + DEBOUNCE_CYCLES clk.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Byte order:
  - Logical value V maps to the bus as {V[7:0],V[15:8],V[23:16],V[31:24]}.
  - Logical write W = byteswap(data_out). Logical byte k is written when data_mask[3-k].
- Registers (word offset from BASE_WORD_ADDR):
  - 0 LEVEL (RO): [N_BUTTONS-1:0] stable buttons, [16+:N_SWITCHES] stable switches, others 0.
  - 1 EDGE (W1C): [N_BUTTONS-1:0] sticky button press (stable 0->1).
  - 2 IRQ_EN (RW): [N_BUTTONS-1:0] interrupt mask, others read 0.
  - 3: reads 0, writes ignored.
- Bus (only when clk_en):
  - Read when bus_lock & !memory_mode & sel: rd_data <= byteswap(reg) on the next edge. rd_data holds otherwise.
  - Write when bus_lock & memory_mode & sel.
- EDGE updates:
  - Edge detection runs every clk.
  - Set and W1C clear in the same cycle: set wins.
  - An edge arriving while clk_en=0 is still captured.
- irq is updated every clk.
- sync_rst mid-debounce aborts the count. After reset, an input held high must be re-accepted after the full 2 + DEBOUNCE_CYCLES.

Optional Feature:
INPUT_COND_RELEASE_EN
- Defined:
  - EDGE[8+:N_BUTTONS] captures releases (stable 1->0), same W1C and set-wins rules.
  - IRQ_EN[8+:N_BUTTONS] masks them into irq.
- Undefined: those bits read 0, writes to them are ignored, and no release logic is built.

Decomposition:
- Package input_cond_pkg holds:
  - localparams REG_LEVEL=0, REG_EDGE=1, REG_IRQ_EN=2.
  - RELEASE_LSB=8, SWITCH_LSB=16.
  - function byteswap32.
- Sub-module debounce_cell: one bit of synchroniser plus counter plus stable flop, with parameters DEBOUNCE_CYCLES and INVERT. Instantiated N_BUTTONS + N_SWITCHES times.

Test Plan:
- DEBOUNCE_CYCLES=4. Hold button0 pin low (pressed) for 10 clk -> LEVEL[0]=1 exactly 6 clk after the change. EDGE read returns bus 32'h01000000.
- Pulse button1 pin low for 3 clk -> LEVEL, EDGE and irq stay 0.
- Capture press on buttons 0 and 2 (EDGE=5). Write bus 32'h01000000 mask 4'b1000 to offset 1 -> EDGE=4. A write with mask 0 leaves EDGE=4.
- IRQ_EN=4, EDGE[2]=1 -> irq=1. On the same cycle as a W1C of bit 2, a new press on button2 arrives -> EDGE[2] stays 1 and irq stays 1.
- clk_en=0 and press button3 -> EDGE[3] set, bus read/write ignored, rd_data held. clk_en=1 and read offset 1 -> rd_data=32'h08000000.
- Assert sync_rst with switch4 at counter 2 -> everything 0. Switch4 becomes stable only 6 clk after reset release. LEVEL read returns bus 32'h00001000.
